pc_unit: RTL

Parametrised program-counter unit for the fetch stage, succeeding the single-source PC. Holds the current fetch address and selects the next one from four sources: sequential increment, external redirect, return-address-stack pop, or exception vector. It also captures the exception PC and keeps a small circular return-address stack (RAS). Downstream fetch logic reads `q_wr` as the instruction address.

---
 rtl/pc_pkg.sv | 39 +++
 rtl/pc_ras.sv | 61 ++++++
 rtl/pc_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types, default vectors and next-PC selection helper for pc_unit
package pc_pkg;

    // Source of the next fetch address, highest priority last
    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_SEQ,
        NPC_REDIR,
        NPC_RET,
        NPC_EXC
    } npc_sel_t;

    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR_DEF   = 32'h0000_1000;
    localparam int unsigned PC_INC_DEF          = 4;
    localparam int unsigned PC_RAS_DEPTH_DEF    = 4;

    // Exception beats everything, including a stalled pipe; otherwise only an
    // enabled cycle may move the PC. ret_ok is already qualified by a non-empty RAS.
    function automatic npc_sel_t npc_select(
        input logic exc,
        input logic wr,
        input logic ret_ok,
        input logic redir
    );
        npc_sel_t sel;
        sel = NPC_HOLD;
        if (exc)
            sel = NPC_EXC;
        else if (wr && ret_ok)
            sel = NPC_RET;
        else if (wr && redir)
            sel = NPC_REDIR;
        else if (wr)
            sel = NPC_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with count, top pointer, push/pop/clear
module pc_ras #(
    parameter int LENGTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [LENGTH-1:0] push_data,
    output logic [LENGTH-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [LENGTH-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     count;
    logic              pop_ok;
    logic              swap;

    // A pop against an empty stack is simply dropped
    assign pop_ok = pop && (count != '0);
    // Push and pop together replace the top in place
    assign swap   = push && pop_ok;

    // Top pointer and occupancy; pushing when full wraps over the oldest entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (swap) begin
            ptr   <= ptr;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (count != COUNT_MAX)
                count <= count + 1'b1;
        end else if (pop_ok) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Entry storage needs no reset; count alone says which entries are live
    always_ff @(posedge clk) begin
        if (!clear && push)
            mem[swap ? ptr : ptr + 1'b1] <= push_data;
    end

    assign top   = mem[ptr];
    assign empty = (count == '0);
    assign full  = (count == COUNT_MAX);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with redirect, exception vector, epc and optional RAS (PC_RAS_EN)
module pc_unit
    import pc_pkg::*;
#(
    parameter int                LENGTH       = 32,
    parameter logic [LENGTH-1:0] RESET_VECTOR = LENGTH'(PC_RESET_VECTOR_DEF),
    parameter logic [LENGTH-1:0] EXC_VECTOR   = LENGTH'(PC_EXC_VECTOR_DEF),
    parameter int unsigned       INC          = PC_INC_DEF,
    parameter int unsigned       RAS_DEPTH    = PC_RAS_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              pc_in,
    input  logic [LENGTH-1:0] p_wr,
    input  logic              exc,
    input  logic              call,
    input  logic              ret,
    output logic [LENGTH-1:0] q_wr,
    output logic [LENGTH-1:0] epc,
    output logic              ras_empty,
    output logic              ras_full
);

    logic [LENGTH-1:0] pc_q;
    logic [LENGTH-1:0] epc_q;
    logic [LENGTH-1:0] link;
    logic [LENGTH-1:0] ras_top;
    logic [LENGTH-1:0] pc_next;
    logic              ret_ok;
    npc_sel_t          sel;

    // Return address for call; additions wrap silently at 2^LENGTH
    assign link = pc_q + LENGTH'(INC);

`ifdef PC_RAS_EN
    logic ras_is_empty;
    logic ras_is_full;

    assign ret_ok = ret && wr && !exc && !ras_is_empty;

    pc_ras #(
        .LENGTH (LENGTH),
        .DEPTH  (int'(RAS_DEPTH))
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (call && wr && !exc),
        .pop       (ret_ok),
        .clear     (exc),
        .push_data (link),
        .top       (ras_top),
        .empty     (ras_is_empty),
        .full      (ras_is_full)
    );

    assign ras_empty = ras_is_empty;
    assign ras_full  = ras_is_full;
`else
    logic unused_ras_in;

    assign unused_ras_in = ^{call, ret};
    assign ret_ok        = 1'b0;
    assign ras_top       = '0;
    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
`endif

    // Pick the next-PC source by priority
    always_comb begin
        sel = npc_select(exc, wr, ret_ok, pc_in);
    end

    // Form the next PC from the selected source
    always_comb begin
        pc_next = pc_q;
        case (sel)
            NPC_EXC:   pc_next = EXC_VECTOR;
            NPC_RET:   pc_next = ras_top;
            NPC_REDIR: pc_next = p_wr;
            NPC_SEQ:   pc_next = link;
            default:   pc_next = pc_q;
        endcase
    end

    // PC register; epc captures the faulting PC whenever an exception is taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
        end else begin
            pc_q <= pc_next;
            if (sel == NPC_EXC)
                epc_q <= pc_q;
        end
    end

    assign q_wr = pc_q;
    assign epc  = epc_q;

endmodule
